// File: rtl/rv32i_pkg.sv
//------------------------------------------------------------------
// rv32i_pkg -- shared fetch types and constants.       Rev 1.0
//------------------------------------------------------------------
`default_nettype none

package rv32i_pkg;

  localparam int          XLEN    = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } ifetch_state_e;

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
//------------------------------------------------------------------
// fetch_queue -- circular FIFO of {pc, instr} with flush. Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module fetch_queue
  import rv32i_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t push_data,
  output fetch_entry_t head,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(QDEPTH);

  fetch_entry_t  mem [QDEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;

  // Entries are cleared on reset so the head reads zero until the first push.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < QDEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + (AW+1)'(1);
      end else if (pop && !push) begin
        count <= count - (AW+1)'(1);
      end
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(QDEPTH));

endmodule

`default_nettype wire

// File: rtl/ifetch_ctrl.sv
//------------------------------------------------------------------
// ifetch_ctrl -- PC owner, IMEM fetch and prefetch queue. Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module ifetch_ctrl
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              QDEPTH   = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            fetch_en,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] Instr_Addr,
  input  logic [XLEN-1:0] Instr_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] fetched_cnt
);

  ifetch_state_e   state;
  ifetch_state_e   state_next;
  logic [XLEN-1:0] fetch_pc;
  logic            enq;
  logic            deq;
  logic            flush;
  logic            q_empty;
  logic            q_full;
  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;
  logic            unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_BOOT;
    end else begin
      state <= state_next;
    end
  end

  // A full queue still accepts a fetch when its head leaves in the same cycle.
  always_comb begin
    state_next = state;
    enq        = 1'b0;
    flush      = 1'b0;
    case (state)
      S_BOOT: state_next = fetch_en ? S_RUN : S_HALT;
      S_RUN: begin
        enq = !redirect_valid && (!q_full || (out_valid && out_ready));
        if (!fetch_en) begin
          state_next = S_HALT;
        end
      end
      S_HALT: begin
        if (fetch_en) begin
          state_next = S_RUN;
        end
      end
      default: state_next = S_BOOT;
    endcase
    if (state != S_BOOT) begin
      flush = redirect_valid;
    end
    deq = out_valid && out_ready && !flush;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc    <= RESET_PC;
      fetched_cnt <= '0;
    end else if (flush) begin
      fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
    end else if (enq) begin
      fetch_pc    <= fetch_pc + PC_STEP;
      fetched_cnt <= fetched_cnt + 32'd1;
    end
  end

  assign push_entry = '{pc: fetch_pc, instr: Instr_rdata};

  fetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .push      (enq),
    .pop       (deq),
    .push_data (push_entry),
    .head      (head_entry),
    .empty     (q_empty),
    .full      (q_full)
  );

  assign Instr_Addr = fetch_pc;
  assign out_valid  = !q_empty;
  assign out_pc     = head_entry.pc;
  assign out_instr  = head_entry.instr;

endmodule

`default_nettype wire
